// File: rtl/mult_controller.sv
// Control FSM for the repeated-addition multiplier: operand handshake, datapath
// strobes, one-cycle done pulse and a sticky stuck-loop error flag.
module mult_controller #(
  parameter int unsigned MAX_ITER = 65536,
  parameter int unsigned CNT_W    = 17
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  input  logic abort,
  input  logic op_valid,
  output logic op_ready,
  input  logic eqz,
  output logic lda,
  output logic ldb,
  output logic ldp,
  output logic clrp,
  output logic decb,
  output logic busy,
  output logic done,
  output logic err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD_A,
    S_LOAD_B,
    S_ACC,
    S_DONE
  } state_t;

  localparam logic [CNT_W:0] LP_MAX = (CNT_W+1)'(MAX_ITER);

  state_t           r_state;
  state_t           w_next;
  logic [CNT_W-1:0] r_iter;
  logic [CNT_W-1:0] w_iter_next;
  logic [CNT_W:0]   w_iter_inc;
  logic             r_err;
  logic             w_err_next;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_iter  <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_next;
      r_iter  <= w_iter_next;
      r_err   <= w_err_next;
    end
  end

  // One extra bit so the overflow compare cannot itself wrap.
  assign w_iter_inc = {1'b0, r_iter} + 1'b1;

  always_comb begin
    w_next      = r_state;
    w_iter_next = r_iter;
    w_err_next  = r_err;
    op_ready    = 1'b0;
    lda         = 1'b0;
    ldb         = 1'b0;
    ldp         = 1'b0;
    clrp        = 1'b0;
    decb        = 1'b0;
    done        = 1'b0;

    if (r_state != S_IDLE && abort) begin
      w_next = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            w_next     = S_LOAD_A;
            w_err_next = 1'b0;
          end
        end
        S_LOAD_A: begin
          op_ready = 1'b1;
          if (op_valid) begin
            lda    = 1'b1;
            w_next = S_LOAD_B;
          end
        end
        S_LOAD_B: begin
          op_ready = 1'b1;
          if (op_valid) begin
            ldb         = 1'b1;
            clrp        = 1'b1;
            w_iter_next = '0;
            w_next      = S_ACC;
          end
        end
        S_ACC: begin
          if (eqz) begin
            w_next = S_DONE;
          end else if (w_iter_inc > LP_MAX) begin
            w_err_next = 1'b1;
            w_next     = S_DONE;
          end else begin
            ldp         = 1'b1;
            decb        = 1'b1;
            w_iter_next = w_iter_inc[CNT_W-1:0];
          end
        end
        S_DONE: begin
          done   = 1'b1;
          w_next = S_IDLE;
        end
        default: w_next = S_IDLE;
      endcase
    end
  end

  assign busy = (r_state == S_LOAD_A) || (r_state == S_LOAD_B) || (r_state == S_ACC);
  assign err  = r_err;

endmodule

// File: tb/tb_mult_controller.sv
// Self-checking bench for mult_controller with a behavioural datapath model
// (A, B, P registers) driven by the controller strobes.
module tb_mult_controller;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    int          sa;
    int          sb;
    logic [15:0] exp_p;
    int          exp_ldp;
    int          exp_lat;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic start2 = 1'b0;
  logic abort = 1'b0;
  logic op_valid = 1'b0;
  logic eqz;
  logic eqz2 = 1'b0;
  logic [15:0] r_data = '0;

  logic op_ready, lda, ldb, ldp, clrp, decb, busy, done, err;
  logic op_ready2, lda2, ldb2, ldp2, clrp2, decb2, busy2, done2, err2;

  logic [15:0] mA = '0;
  logic [15:0] mB = '0;
  logic [15:0] mP = '0;

  int errors = 0;
  int checks = 0;
  int viol = 0;
  vec_t vecs[6];

  always #5 clk = ~clk;

  assign eqz = (mB == 16'd0);

  mult_controller dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .op_valid(op_valid),
    .op_ready(op_ready), .eqz(eqz), .lda(lda), .ldb(ldb), .ldp(ldp), .clrp(clrp),
    .decb(decb), .busy(busy), .done(done), .err(err)
  );

  mult_controller #(.MAX_ITER(8), .CNT_W(4)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .abort(abort), .op_valid(op_valid),
    .op_ready(op_ready2), .eqz(eqz2), .lda(lda2), .ldb(ldb2), .ldp(ldp2), .clrp(clrp2),
    .decb(decb2), .busy(busy2), .done(done2), .err(err2)
  );

  always @(posedge clk) begin
    if (lda) mA <= r_data;
    if (ldb) mB <= r_data;
    else if (decb) mB <= mB - 16'd1;
    if (clrp) mP <= '0;
    else if (ldp) mP <= mP + mA;
  end

  always @(negedge clk) begin
    #2;
    if ((lda & ldb) === 1'b1 || (ldp & clrp) === 1'b1) viol++;
    if ((lda2 & ldb2) === 1'b1 || (ldp2 & clrp2) === 1'b1) viol++;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Called at a negedge; that cycle is cycle 0 (start high). lat counts cycles
  // from the start cycle through the done cycle inclusive, 0 on timeout.
  task automatic run_op(input logic [15:0] a, input logic [15:0] b, input int sa, input int sb,
                        output int lat, output int nldp, output int bad);
    int oi;
    int sc;
    lat = 0; nldp = 0; bad = 0; oi = 0; sc = 0;
    start = 1'b1;
    op_valid = 1'b0;
    for (int c = 1; c < 400 && lat == 0; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (oi < 2 && sc >= ((oi == 0) ? sa : sb)) begin
        op_valid = 1'b1;
        r_data = (oi == 0) ? a : b;
      end else begin
        op_valid = 1'b0;
        r_data = 16'hDEAD;
      end
      #1;
      if (oi < 2 && op_ready !== 1'b1) bad++;
      if (lda !== (op_valid && oi == 0)) bad++;
      if (ldb !== (op_valid && oi == 1)) bad++;
      if (ldp === 1'b1) nldp++;
      if (done === 1'b1) lat = c + 1;
      if (oi < 2) begin
        if (op_valid) begin oi++; sc = 0; end
        else sc++;
      end
    end
    op_valid = 1'b0;
  endtask

  initial begin
    int lat, nldp, bad, n2, d2, dcnt;
    logic e2;

    vecs[0] = '{16'd5,     16'd3,   0, 0, 16'd15,    3,   8};
    vecs[1] = '{16'd7,     16'd0,   0, 0, 16'd0,     0,   5};
    vecs[2] = '{16'd9,     16'd4,   3, 3, 16'd36,    4,   15};
    vecs[3] = '{16'hFFFF,  16'd2,   0, 0, 16'hFFFE,  2,   7};
    vecs[4] = '{16'd300,   16'd300, 0, 0, 16'd24464, 300, 305};
    vecs[5] = '{16'd1,     16'd1,   1, 0, 16'd1,     1,   7};

    rst_n = 1'b0;
    start = 1'b1;
    abort = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    chk("reset outputs", {23'd0, op_ready, lda, ldb, ldp, clrp, decb, busy, done, err}, 32'd0);
    chk("reset outputs dut2", {23'd0, op_ready2, lda2, ldb2, ldp2, clrp2, decb2, busy2, done2, err2}, 32'd0);
    start = 1'b0;
    abort = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 6; i++) begin
      run_op(vecs[i].a, vecs[i].b, vecs[i].sa, vecs[i].sb, lat, nldp, bad);
      chk($sformatf("vec%0d P", i), {16'd0, mP}, {16'd0, vecs[i].exp_p});
      chk($sformatf("vec%0d ldp count", i), nldp, vecs[i].exp_ldp);
      chk($sformatf("vec%0d latency", i), lat, vecs[i].exp_lat);
      chk($sformatf("vec%0d handshake", i), bad, 0);
      chk($sformatf("vec%0d err", i), {31'd0, err}, 32'd0);
      @(negedge clk);
      #1;
      chk($sformatf("vec%0d idle after done", i), {30'd0, busy, done}, 32'd0);
    end

    // Abort in the 4th ACC cycle of A=3, B=10.
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0; op_valid = 1'b1; r_data = 16'd3;
    @(negedge clk);
    r_data = 16'd10;
    @(negedge clk);
    op_valid = 1'b0;
    repeat (3) @(negedge clk);
    abort = 1'b1;
    #1;
    chk("abort strobes", {26'd0, ldp, decb, lda, ldb, clrp, done}, 32'd0);
    chk("abort partial P", {16'd0, mP}, 32'd9);
    @(negedge clk);
    abort = 1'b0;
    #1;
    chk("abort idle", {30'd0, busy, op_ready}, 32'd0);
    dcnt = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      #1;
      if (done === 1'b1) dcnt++;
    end
    chk("abort no done", dcnt, 0);
    run_op(16'd2, 16'd2, 0, 0, lat, nldp, bad);
    chk("after abort P", {16'd0, mP}, 32'd4);
    chk("after abort latency", lat, 7);
    @(negedge clk);

    // Reset pulse in the middle of ACC, then immediate start.
    start = 1'b1;
    @(negedge clk);
    start = 1'b0; op_valid = 1'b1; r_data = 16'd4;
    @(negedge clk);
    r_data = 16'd6;
    @(negedge clk);
    op_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("mid reset outputs", {23'd0, op_ready, lda, ldb, ldp, clrp, decb, busy, done, err}, 32'd0);
    run_op(16'd2, 16'd3, 0, 0, lat, nldp, bad);
    chk("post reset latency", lat, 8);
    chk("post reset P", {16'd0, mP}, 32'd6);
    @(negedge clk);

    // Iteration overflow on the MAX_ITER=8 instance with eqz held low.
    eqz2 = 1'b0;
    start2 = 1'b1;
    n2 = 0; d2 = 0; e2 = 1'b0;
    for (int c = 1; c < 40 && d2 == 0; c++) begin
      @(negedge clk);
      start2 = 1'b0;
      op_valid = (c <= 2);
      r_data = 16'd1;
      #1;
      if (ldp2 === 1'b1) n2++;
      if (done2 === 1'b1) begin d2 = c; e2 = err2; end
    end
    op_valid = 1'b0;
    chk("overflow ldp count", n2, 8);
    chk("overflow done cycle", d2, 12);
    chk("overflow err at done", {31'd0, e2}, 32'd1);
    repeat (3) @(negedge clk);
    #1;
    chk("err sticky in idle", {30'd0, err2, busy2}, 32'd2);
    @(negedge clk);
    eqz2 = 1'b1;
    start2 = 1'b1;
    #1;
    chk("err before start accepted", {31'd0, err2}, 32'd1);
    @(negedge clk);
    start2 = 1'b0;
    #1;
    chk("err cleared by start", {30'd0, err2, busy2}, 32'd1);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;

    chk("strobe exclusivity", viol, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
